filter_fir_ctrl: RTL and testbench
==================================

// Module: filter_fir_ctrl
// PURPOSE
//  Burst sequencer for the filter_FIR moving-average datapath in the speckle sensor readout chain.
//  On i_start it flushes the filter, streams i_len ADC samples through it (one per clock), discards the
//  ORDER-sample warm-up, decimates by DECIM and buffers results in a FIFO towards a valid/ready consumer.
// PARAMETERS
//  NB_DATA    12  sample/result width (matches filter)
//  ORDER       4  filter order; first ORDER filter outputs of a burst are invalid
//  DECIM       4  keep 1 of every DECIM valid filter outputs (>=1)
//  NB_LEN     16  width of burst length
//  FIFO_DEPTH  8  result buffer entries (power of 2)
// PORTS
//  clk            in   1        clock
//  rst            in   1        asynchronous reset, active-high
//  i_start        in   1        start burst (sampled in IDLE only)
//  i_len          in   NB_LEN   samples in burst, captured on accepted i_start
//  i_sample_valid in   1        ADC sample present this cycle
//  i_sample       in   NB_DATA  ADC sample
//  i_clear_err    in   1        clears sticky error flags
//  o_flt_rst      out  1        filter sync reset; =1 while rst=1 and in FLUSH
//  o_flt_sample   out  NB_DATA  filter input
//  i_flt_out      in   NB_DATA  filter output (combinational from o_flt_sample)
//  o_data         out  NB_DATA  FIFO head
//  o_valid        out  1        FIFO non-empty
//  i_ready        in   1        consumer accepts o_data when o_valid&i_ready
//  o_busy         out  1        state != IDLE
//  o_done         out  1        1-cycle pulse, burst complete and FIFO drained
//  o_overflow     out  1        sticky: result dropped, FIFO full
//  o_underrun     out  1        sticky: i_sample_valid=0 during RUN
// BEHAVIOUR
//  Reset (async): state IDLE, counters 0, FIFO empty; o_valid/o_busy/o_done/flags=0, o_flt_sample=0.
//  States: IDLE -i_start-> FLUSH (1 cycle) -> RUN (if len>0) | DRAIN (if len==0);
//    RUN -k==len-1-> DRAIN; DRAIN -FIFO empty-> DONE (1 cycle, o_done=1) -> IDLE.
//  i_start outside IDLE ignored; i_len not re-sampled mid-burst.
//  RUN: sample counter k=0..len-1, +1 every cycle regardless of valid. o_flt_sample=i_sample when
//    i_sample_valid else 0, and o_underrun<=1 (burst continues). Outside RUN o_flt_sample=0.
//  Result k valid iff k>=ORDER and (k-ORDER)%DECIM==0 (decim phase counter, no divider);
//    on valid push i_flt_out unmodified (no rescale) into FIFO in same cycle.
//  Results per burst = len>ORDER ? (len-ORDER-1)/DECIM+1 : 0.
//  FIFO: push accepted if !full or pop same cycle; else result dropped, o_overflow<=1.
//    Pop on o_valid&i_ready; o_data stable while o_valid&!i_ready. Empty pop impossible.
//  i_clear_err clears both flags; a same-cycle set wins over clear.
//  Reset mid-operation: immediate IDLE, FIFO contents discarded, no o_done.
//  Latency: first result available in FIFO one clock after RUN cycle k=ORDER.
// STRUCTURE
//  Shared package filter_ctrl_pkg: state encoding (IDLE,FLUSH,RUN,DRAIN,DONE) localparams.
//  Sub-module: sync_fifo (NB_DATA x FIFO_DEPTH, full/empty, async active-high rst).
//  Top: FSM, sample counter, decim counter, flag regs, filter_FIR instance not included (external).
// TESTING (ORDER=4, DECIM=4, FIFO_DEPTH=8; filter out = sum of 5 samples >>2)
//  1 Assert rst mid-idle -> all outputs 0, o_flt_rst=1; release -> o_flt_rst=0, IDLE.
//  2 len=12, const 100, ready=1 -> exactly 2 results of 125 (k=4,8), then o_done one pulse.
//  3 len=12, ramp sample k=k+1 -> results 3 (15>>2) and 8 (35>>2), in order.
//  4 len=40, ready=0 -> 9 results, 8 stored, o_overflow=1; ready=1 -> 8 pops, o_done.
//  5 len=12, valid low at k=6 -> o_underrun=1, zero fed, burst completes; i_clear_err -> 0.
//  6 len=3 -> no results, o_done; rst during RUN -> IDLE, o_valid=0, next start runs cleanly.

Source files
------------

// File: rtl/filter_fir_ctrl_pkg.sv
// Shared definitions for the filter_FIR burst sequencer: default sizes,
// FSM state encoding and a small width helper.
package filter_ctrl_pkg;

    localparam int NB_DATA_DEF    = 12;
    localparam int ORDER_DEF      = 4;
    localparam int DECIM_DEF      = 4;
    localparam int NB_LEN_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/filter_fir_ctrl_if.sv
// Valid/ready result stream from the sequencer FIFO to the consumer.
interface filter_fir_ctrl_if
    import filter_ctrl_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
) ();

    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               i_ready;

    modport master (
        output o_data,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output i_ready
    );

endinterface

// File: rtl/filter_fir_ctrl_sync_fifo.sv
// Synchronous FIFO buffering filter results. A push into a full FIFO is
// still accepted when a pop happens in the same cycle. DEPTH must be a
// power of two so the pointers wrap naturally.
module sync_fifo
    import filter_ctrl_pkg::*;
#(
    parameter int WIDTH = NB_DATA_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2_min1(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy tracking; reset discards all stored entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/filter_fir_ctrl.sv
// Burst sequencer for the external filter_FIR moving-average datapath:
// flushes the filter, streams a burst of samples, skips the warm-up
// outputs, decimates and queues the results for a valid/ready consumer.
module filter_fir_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int NB_DATA    = NB_DATA_DEF,
    parameter int ORDER      = ORDER_DEF,
    parameter int DECIM      = DECIM_DEF,
    parameter int NB_LEN     = NB_LEN_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [NB_LEN-1:0]  i_len,
    input  logic               i_sample_valid,
    input  logic [NB_DATA-1:0] i_sample,
    input  logic               i_clear_err,
    output logic               o_flt_rst,
    output logic [NB_DATA-1:0] o_flt_sample,
    input  logic [NB_DATA-1:0] i_flt_out,
    filter_fir_ctrl_if.master  out_bus,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic               o_underrun
);

    localparam int                PH_W    = clog2_min1(DECIM);
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(DECIM - 1);
    localparam logic [NB_LEN-1:0] K_FIRST = NB_LEN'(ORDER);

    state_t              state;
    state_t              state_nxt;
    logic [NB_LEN-1:0]   len_q;
    logic [NB_LEN-1:0]   k_q;
    logic [PH_W-1:0]     phase_q;
    logic                flush;
    logic                run_last;
    logic                past_warmup;
    logic                res_valid;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                push_drop;

    assign run_last    = (k_q == (len_q - NB_LEN'(1)));
    assign past_warmup = (k_q >= K_FIRST);
    assign res_valid   = (state == ST_RUN) && past_warmup && (phase_q == '0);
    assign fifo_pop    = out_bus.o_valid && out_bus.i_ready;
    assign push_drop   = res_valid && fifo_full && !fifo_pop;
    assign o_flt_rst   = rst || flush;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs; the filter only sees real samples during RUN.
    always_comb begin
        state_nxt    = state;
        flush        = 1'b0;
        o_busy       = (state != ST_IDLE);
        o_done       = 1'b0;
        o_flt_sample = '0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush     = 1'b1;
                state_nxt = (len_q == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (i_sample_valid) begin
                    o_flt_sample = i_sample;
                end
                if (run_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst length is latched only when a start is accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
        end else if ((state == ST_IDLE) && i_start) begin
            len_q <= i_len;
        end
    end

    // Sample index and decimation phase; phase only advances once warm-up is over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            phase_q <= '0;
        end else if (state == ST_RUN) begin
            k_q <= k_q + NB_LEN'(1);
            if (past_warmup) begin
                phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            end
        end else begin
            k_q     <= '0;
            phase_q <= '0;
        end
    end

    // Sticky error flags; a new error in the same cycle beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_overflow <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            if (push_drop) begin
                o_overflow <= 1'b1;
            end else if (i_clear_err) begin
                o_overflow <= 1'b0;
            end
            if ((state == ST_RUN) && !i_sample_valid) begin
                o_underrun <= 1'b1;
            end else if (i_clear_err) begin
                o_underrun <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (NB_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_valid),
        .push_data (i_flt_out),
        .pop       (fifo_pop),
        .pop_data  (out_bus.o_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_bus.o_valid = !fifo_empty;

endmodule

// File: tb/tb_filter_fir_ctrl.sv
// Directed bench for filter_fir_ctrl with a behavioural 5-tap moving-sum filter (>>2).
module tb_filter_fir_ctrl;
    import filter_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [15:0] i_len;
    logic        i_sample_valid;
    logic [11:0] i_sample;
    logic        i_clear_err;
    logic        o_flt_rst;
    logic [11:0] o_flt_sample;
    logic [11:0] i_flt_out;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;
    logic        o_underrun;

    filter_fir_ctrl_if #(.NB_DATA(12)) out_bus ();

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    logic [11:0] got [$];

    logic [11:0] hist [4];
    logic [14:0] flt_sum;

    always #5 clk = ~clk;

    filter_fir_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_len          (i_len),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_clear_err    (i_clear_err),
        .o_flt_rst      (o_flt_rst),
        .o_flt_sample   (o_flt_sample),
        .i_flt_out      (i_flt_out),
        .out_bus        (out_bus),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_overflow     (o_overflow),
        .o_underrun     (o_underrun)
    );

    // External filter model: four-deep history with synchronous clear.
    always @(posedge clk) begin
        if (o_flt_rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else begin
            hist[0] <= o_flt_sample;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
        end
    end

    // Filter output is combinational from the current sample.
    always_comb begin
        flt_sum   = 15'(o_flt_sample) + 15'(hist[0]) + 15'(hist[1]) + 15'(hist[2]) + 15'(hist[3]);
        i_flt_out = flt_sum[13:2];
    end

    // Record accepted results and done pulses between clock edges.
    always @(negedge clk) begin
        if (out_bus.o_valid && out_bus.i_ready) got.push_back(out_bus.o_data);
        if (o_done) done_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input int idx, input logic [31:0] expected);
        logic [31:0] observed;
        observed = (idx < got.size()) ? 32'(got[idx]) : 32'hFFFF_FFFF;
        checkOutput(tag, observed, expected);
    endtask

    // mode 0: constant 100, mode 1: ramp k+1; gap_k drops valid at that index.
    task automatic applyStimulus(input int len, input int mode, input int gap_k, input bit chk_lat);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_len   = 16'(len);
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < len; k++) begin
            i_sample_valid = (k != gap_k);
            i_sample       = (mode == 0) ? 12'd100 : 12'(k + 1);
            if (chk_lat && k == 4) checkOutput("lat_before", 32'(out_bus.o_valid), 0);
            if (chk_lat && k == 5) checkOutput("lat_after", 32'(out_bus.o_valid), 1);
            @(posedge clk); #1;
        end
        i_sample_valid = 1'b0;
        i_sample       = '0;
    endtask

    task automatic waitDone(input string tag, input int base);
        for (int i = 0; i < 400 && done_cnt == base; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput(tag, 32'(done_cnt - base), 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gb;
        int db;
        rst = 1'b1;
        i_start = 1'b0;
        i_len = '0;
        i_sample_valid = 1'b0;
        i_sample = '0;
        i_clear_err = 1'b0;
        out_bus.i_ready = 1'b0;

        // Test 1: reset state, async assertion while idle.
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(out_bus.o_valid), 0);
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_done", 32'(o_done), 0);
        checkOutput("rst_ovf", 32'(o_overflow), 0);
        checkOutput("rst_udr", 32'(o_underrun), 0);
        checkOutput("rst_flt_sample", 32'(o_flt_sample), 0);
        checkOutput("rst_flt_rst", 32'(o_flt_rst), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rel_flt_rst", 32'(o_flt_rst), 0);
        #2 rst = 1'b1;
        #1 checkOutput("async_flt_rst", 32'(o_flt_rst), 1);
        checkOutput("async_busy", 32'(o_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_flt_rst", 32'(o_flt_rst), 0);
        checkOutput("idle_busy", 32'(o_busy), 0);

        // Test 2: constant 100, two results of 125.
        out_bus.i_ready = 1'b1;
        gb = got.size();
        db = done_cnt;
        applyStimulus(12, 0, -1, 1'b1);
        waitDone("t2_done", db);
        checkOutput("t2_count", 32'(got.size() - gb), 2);
        checkResult("t2_r0", gb, 125);
        checkResult("t2_r1", gb + 1, 125);
        checkOutput("t2_busy", 32'(o_busy), 0);

        // Test 3: ramp, results 3 then 8.
        gb = got.size();
        db = done_cnt;
        applyStimulus(12, 1, -1, 1'b0);
        waitDone("t3_done", db);
        checkOutput("t3_count", 32'(got.size() - gb), 2);
        checkResult("t3_r0", gb, 3);
        checkResult("t3_r1", gb + 1, 8);

        // Test 4: len 40 ramp with consumer stalled; ninth result dropped.
        @(posedge clk); #1;
        out_bus.i_ready = 1'b0;
        gb = got.size();
        db = done_cnt;
        applyStimulus(40, 1, -1, 1'b0);
        @(negedge clk);
        checkOutput("t4_ovf", 32'(o_overflow), 1);
        checkOutput("t4_valid", 32'(out_bus.o_valid), 1);
        checkOutput("t4_head", 32'(out_bus.o_data), 3);
        checkOutput("t4_busy", 32'(o_busy), 1);
        checkOutput("t4_no_pop", 32'(got.size() - gb), 0);
        checkOutput("t4_no_done", 32'(done_cnt - db), 0);
        @(posedge clk); #1;
        out_bus.i_ready = 1'b1;
        waitDone("t4_done", db);
        checkOutput("t4_count", 32'(got.size() - gb), 8);
        for (int i = 0; i < 8; i++) checkResult($sformatf("t4_r%0d", i), gb + i, 32'(3 + 5 * i));
        @(posedge clk); #1;
        i_clear_err = 1'b1;
        @(posedge clk); #1;
        i_clear_err = 1'b0;
        @(negedge clk);
        checkOutput("t4_ovf_clr", 32'(o_overflow), 0);

        // Test 5: valid low at k=6, zero fed to filter.
        gb = got.size();
        db = done_cnt;
        applyStimulus(12, 0, 6, 1'b0);
        waitDone("t5_done", db);
        checkOutput("t5_count", 32'(got.size() - gb), 2);
        checkResult("t5_r0", gb, 125);
        checkResult("t5_r1", gb + 1, 100);
        checkOutput("t5_udr", 32'(o_underrun), 1);
        checkOutput("t5_ovf", 32'(o_overflow), 0);
        @(posedge clk); #1;
        i_clear_err = 1'b1;
        @(posedge clk); #1;
        i_clear_err = 1'b0;
        @(negedge clk);
        checkOutput("t5_udr_clr", 32'(o_underrun), 0);

        // Test 6: short burst, then reset during RUN and a clean rerun.
        gb = got.size();
        db = done_cnt;
        applyStimulus(3, 0, -1, 1'b0);
        waitDone("t6_short_done", db);
        checkOutput("t6_short_count", 32'(got.size() - gb), 0);

        out_bus.i_ready = 1'b0;
        db = done_cnt;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_len   = 16'd20;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_sample_valid = 1'b1;
        i_sample = 12'd100;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("t6_pre_valid", 32'(out_bus.o_valid), 1);
        checkOutput("t6_pre_busy", 32'(o_busy), 1);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_valid", 32'(out_bus.o_valid), 0);
        checkOutput("t6_rst_busy", 32'(o_busy), 0);
        checkOutput("t6_rst_flt_rst", 32'(o_flt_rst), 1);
        checkOutput("t6_rst_flt_sample", 32'(o_flt_sample), 0);
        i_sample_valid = 1'b0;
        i_sample = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t6_no_done", 32'(done_cnt - db), 0);
        out_bus.i_ready = 1'b1;
        gb = got.size();
        db = done_cnt;
        applyStimulus(12, 0, -1, 1'b0);
        waitDone("t6_rerun_done", db);
        checkOutput("t6_rerun_count", 32'(got.size() - gb), 2);
        checkResult("t6_rerun_r0", gb, 125);
        checkResult("t6_rerun_r1", gb + 1, 125);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
